// File: rtl/keypad_entry.sv
// Keypad operand/operator assembler: builds two BCD operands and an operator,
// then issues them over valid/ready. Optional macro: KEYPAD_ENTRY_BACKSPACE_EN.
module keypad_entry #(
   parameter int DIGITS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_key_valid,
   input  logic [3:0]          i_key_code,
   output logic                o_op_valid,
   input  logic                i_op_ready,
   output logic [4*DIGITS-1:0] o_operand_a,
   output logic [4*DIGITS-1:0] o_operand_b,
   output logic [1:0]          o_op_code,
   output logic [4*DIGITS-1:0] o_entry_value,
   output logic [3:0]          o_entry_count,
   output logic                o_entry_sel
);

   localparam int         W        = 4 * DIGITS;
   localparam logic [3:0] CNT_FULL = 4'(DIGITS);
   localparam logic [3:0] KEY_HASH = 4'd14;
   localparam logic [3:0] KEY_STAR = 4'd15;

   typedef enum logic [1:0] {
      ENTRY_A = 2'd0,
      ENTRY_B = 2'd1,
      ISSUE   = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_a, r_b;
   logic [W-1:0] w_a_nxt, w_b_nxt;
   logic [1:0]   r_op, w_op_nxt;
   logic [3:0]   r_cnt_a, r_cnt_b;
   logic [3:0]   w_cnt_a_nxt, w_cnt_b_nxt;
   logic         w_clr;

   logic         w_is_digit;
   logic         w_is_op;
   logic         w_is_hash;
   logic         w_is_star;
   logic [1:0]   w_op_key;

   assign w_is_digit = (i_key_code <= 4'd9);
   assign w_is_op    = (i_key_code >= 4'd10) && (i_key_code <= 4'd13);
   assign w_is_hash  = (i_key_code == KEY_HASH);
   assign w_is_star  = (i_key_code == KEY_STAR);
   // codes 10..13 map to 0..3: low two bits plus 2, modulo 4
   assign w_op_key   = i_key_code[1:0] + 2'd2;

   function automatic logic digit_ok(input logic [3:0] cnt, input logic [3:0] code);
      digit_ok = (cnt < CNT_FULL) && !((code == 4'd0) && (cnt == 4'd0));
   endfunction

   function automatic logic [W-1:0] shift_in(input logic [W-1:0] val, input logic [3:0] code);
      logic [W-1:0] f;
      f      = val << 4;
      f[3:0] = code;
      shift_in = f;
   endfunction

`ifdef KEYPAD_ENTRY_BACKSPACE_EN
   function automatic logic [W-1:0] shift_out(input logic [W-1:0] val);
      shift_out = val >> 4;
   endfunction
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ENTRY_A;
      else       r_state <= w_state_nxt;
   end

   // next state plus next datapath values; keys are only honoured in the entry states
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_cnt_a_nxt = r_cnt_a;
      w_cnt_b_nxt = r_cnt_b;
      w_clr       = 1'b0;
      case (r_state)
         ENTRY_A: begin
            if (i_key_valid) begin
               if (w_is_digit) begin
                  if (digit_ok(r_cnt_a, i_key_code)) begin
                     w_a_nxt     = shift_in(r_a, i_key_code);
                     w_cnt_a_nxt = r_cnt_a + 4'd1;
                  end
               end else if (w_is_op) begin
                  w_op_nxt    = w_op_key;
                  w_state_nxt = ENTRY_B;
               end else if (w_is_star) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                  if (r_cnt_a != 4'd0) begin
                     w_a_nxt     = shift_out(r_a);
                     w_cnt_a_nxt = r_cnt_a - 4'd1;
                  end else begin
                     w_clr = 1'b1;
                  end
`else
                  w_clr = 1'b1;
`endif
               end
            end
         end
         ENTRY_B: begin
            if (i_key_valid) begin
               if (w_is_digit) begin
                  if (digit_ok(r_cnt_b, i_key_code)) begin
                     w_b_nxt     = shift_in(r_b, i_key_code);
                     w_cnt_b_nxt = r_cnt_b + 4'd1;
                  end
               end else if (w_is_op) begin
                  if (r_cnt_b == 4'd0) w_op_nxt = w_op_key;
               end else if (w_is_hash) begin
                  w_state_nxt = ISSUE;
               end else if (w_is_star) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                  if (r_cnt_b != 4'd0) begin
                     w_b_nxt     = shift_out(r_b);
                     w_cnt_b_nxt = r_cnt_b - 4'd1;
                  end else begin
                     w_state_nxt = ENTRY_A;
                  end
`else
                  w_clr = 1'b1;
`endif
               end
            end
         end
         ISSUE: begin
            if (i_op_ready) w_clr = 1'b1;
         end
         default: begin
            w_clr = 1'b1;
         end
      endcase
      if (w_clr) begin
         w_state_nxt = ENTRY_A;
         w_a_nxt     = '0;
         w_b_nxt     = '0;
         w_op_nxt    = 2'd0;
         w_cnt_a_nxt = 4'd0;
         w_cnt_b_nxt = 4'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= 2'd0;
         r_cnt_a <= 4'd0;
         r_cnt_b <= 4'd0;
      end else begin
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
         r_cnt_a <= w_cnt_a_nxt;
         r_cnt_b <= w_cnt_b_nxt;
      end
   end

   always_comb begin
      o_op_valid    = (r_state == ISSUE);
      o_entry_sel   = (r_state != ENTRY_A);
      o_entry_value = (r_state == ENTRY_A) ? r_a : r_b;
      o_entry_count = (r_state == ENTRY_A) ? r_cnt_a : r_cnt_b;
   end

   assign o_operand_a = r_a;
   assign o_operand_b = r_b;
   assign o_op_code   = r_op;

endmodule

// File: tb/tb_keypad_entry.sv
// Table-driven bench for keypad_entry (DIGITS=4) with hand sequences for
// the long-hold, asynchronous reset and optional backspace cases.
module tb_keypad_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        op_ready = 1'b0;
   logic        op_valid;
   logic [15:0] operand_a, operand_b, entry_value;
   logic [1:0]  op_code;
   logic [3:0]  entry_count;
   logic        entry_sel;

   int errors = 0;
   int checks = 0;

   keypad_entry #(.DIGITS(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_key_valid  (key_valid),
      .i_key_code   (key_code),
      .o_op_valid   (op_valid),
      .i_op_ready   (op_ready),
      .o_operand_a  (operand_a),
      .o_operand_b  (operand_b),
      .o_op_code    (op_code),
      .o_entry_value(entry_value),
      .o_entry_count(entry_count),
      .o_entry_sel  (entry_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        kv;
      logic [3:0]  kc;
      logic        rdy;
      logic        ev;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [1:0]  eop;
      logic [15:0] ee;
      logic [3:0]  ec;
      logic        es;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic rdy,
                               input logic ev, input logic [15:0] ea, input logic [15:0] eb,
                               input logic [1:0] eop, input logic [15:0] ee,
                               input logic [3:0] ec, input logic es);
      vec_t v;
      v.kv = kv; v.kc = kc; v.rdy = rdy; v.ev = ev; v.ea = ea; v.eb = eb;
      v.eop = eop; v.ee = ee; v.ec = ec; v.es = es;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [15:0] ea,
                            input logic [15:0] eb, input logic [1:0] eop,
                            input logic [15:0] ee, input logic [3:0] ec, input logic es);
      cmp({tag, ".op_valid"}, 16'(op_valid), 16'(ev));
      cmp({tag, ".operand_a"}, operand_a, ea);
      cmp({tag, ".operand_b"}, operand_b, eb);
      cmp({tag, ".op_code"}, 16'(op_code), 16'(eop));
      cmp({tag, ".entry_value"}, entry_value, ee);
      cmp({tag, ".entry_count"}, 16'(entry_count), 16'(ec));
      cmp({tag, ".entry_sel"}, 16'(entry_sel), 16'(es));
   endtask

   // drive on negedge, let one posedge pass, return on the following negedge
   task automatic step(input logic kv, input logic [3:0] kc, input logic rdy);
      key_valid = kv;
      key_code  = kc;
      op_ready  = rdy;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      op_ready  = 1'b0;
   endtask

   initial begin
      // operator sequence with op_ready toggled while not valid
      vecs.push_back(mk(1, 1,  0, 0, 16'h0001, 16'h0000, 0, 16'h0001, 1, 0));
      vecs.push_back(mk(1, 2,  1, 0, 16'h0012, 16'h0000, 0, 16'h0012, 2, 0));
      vecs.push_back(mk(1, 10, 0, 0, 16'h0012, 16'h0000, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 3,  0, 0, 16'h0012, 16'h0003, 0, 16'h0003, 1, 1));
      vecs.push_back(mk(1, 4,  0, 0, 16'h0012, 16'h0034, 0, 16'h0034, 2, 1));
      vecs.push_back(mk(1, 14, 0, 1, 16'h0012, 16'h0034, 0, 16'h0034, 2, 1));
      vecs.push_back(mk(0, 0,  0, 1, 16'h0012, 16'h0034, 0, 16'h0034, 2, 1));
      vecs.push_back(mk(1, 9,  0, 1, 16'h0012, 16'h0034, 0, 16'h0034, 2, 1));
      vecs.push_back(mk(1, 15, 0, 1, 16'h0012, 16'h0034, 0, 16'h0034, 2, 1));
      vecs.push_back(mk(0, 0,  1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      // leading zeros and full operand
      vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(1, 7,  0, 0, 16'h0007, 16'h0000, 0, 16'h0007, 1, 0));
      vecs.push_back(mk(1, 9,  0, 0, 16'h0079, 16'h0000, 0, 16'h0079, 2, 0));
      vecs.push_back(mk(1, 8,  0, 0, 16'h0798, 16'h0000, 0, 16'h0798, 3, 0));
      vecs.push_back(mk(1, 7,  0, 0, 16'h7987, 16'h0000, 0, 16'h7987, 4, 0));
      vecs.push_back(mk(1, 6,  0, 0, 16'h7987, 16'h0000, 0, 16'h7987, 4, 0));
      vecs.push_back(mk(1, 5,  0, 0, 16'h7987, 16'h0000, 0, 16'h7987, 4, 0));
      vecs.push_back(mk(1, 10, 0, 0, 16'h7987, 16'h0000, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 14, 0, 1, 16'h7987, 16'h0000, 0, 16'h0000, 0, 1));
      // key during the completing handshake is dropped
      vecs.push_back(mk(1, 7,  1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, 0,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(1, 14, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      // operator replacement, late operator ignored
      vecs.push_back(mk(1, 5,  0, 0, 16'h0005, 16'h0000, 0, 16'h0005, 1, 0));
      vecs.push_back(mk(1, 12, 0, 0, 16'h0005, 16'h0000, 2, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 11, 0, 0, 16'h0005, 16'h0000, 1, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 2,  0, 0, 16'h0005, 16'h0002, 1, 16'h0002, 1, 1));
      vecs.push_back(mk(1, 13, 0, 0, 16'h0005, 16'h0002, 1, 16'h0002, 1, 1));
      vecs.push_back(mk(1, 14, 0, 1, 16'h0005, 16'h0002, 1, 16'h0002, 1, 1));
      vecs.push_back(mk(0, 0,  1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
      // empty A with divide operator
      vecs.push_back(mk(1, 13, 0, 0, 16'h0000, 16'h0000, 3, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 14, 0, 1, 16'h0000, 16'h0000, 3, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 0,  1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));

      repeat (2) @(negedge clk);
      check_all("reset", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].kv, vecs[i].kc, vecs[i].rdy);
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].eb,
                   vecs[i].eop, vecs[i].ee, vecs[i].ec, vecs[i].es);
      end

      // expression held for 10 cycles while op_ready stays low
      step(1, 1, 0); step(1, 11, 0); step(1, 2, 0); step(1, 14, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         check_all($sformatf("hold%0d", i), 1, 16'h0001, 16'h0002, 1, 16'h0002, 1, 1);
      end
      step(0, 0, 1);
      check_all("hold_done", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);

      // asynchronous reset mid-entry, observed before any clock edge
      step(1, 3, 0); step(1, 10, 0); step(1, 4, 0);
      check_all("pre_rst", 0, 16'h0003, 16'h0004, 0, 16'h0004, 1, 1);
      #2 rst = 1'b1;
      #1 check_all("async_rst", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      step(1, 6, 0);
      check_all("post_rst", 0, 16'h0006, 16'h0, 0, 16'h0006, 1, 0);

      // reset once more to start the star tests from a clean entry
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

`ifdef KEYPAD_ENTRY_BACKSPACE_EN
      step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 15, 0);
      check_all("bs_a", 0, 16'h0012, 16'h0, 0, 16'h0012, 2, 0);
      step(1, 10, 0);
      check_all("bs_op", 0, 16'h0012, 16'h0, 0, 16'h0000, 0, 1);
      step(1, 15, 0);
      check_all("bs_back", 0, 16'h0012, 16'h0, 0, 16'h0012, 2, 0);
      step(1, 15, 0); step(1, 15, 0);
      check_all("bs_empty", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
      step(1, 4, 0); step(1, 15, 0); step(1, 15, 0);
      check_all("bs_clear", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
`else
      step(1, 1, 0); step(1, 12, 0); step(1, 2, 0);
      check_all("pre_clr", 0, 16'h0001, 16'h0002, 2, 16'h0002, 1, 1);
      step(1, 15, 0);
      check_all("clr_b", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
      step(1, 5, 0); step(1, 8, 0); step(1, 15, 0);
      check_all("clr_a", 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Operand/operator assembler sitting directly downstream of the keypad scanner. Consumes one decoded 4-bit key code per press strobe and builds two BCD operands plus an operator. Issues the completed expression to the calculator core over a valid/ready handshake, and exposes the in-progress entry for the display driver.

## Interface
Parameters:
- DIGITS, 4, max BCD digits per operand (1..8)

Ports:
- clk  input  1  system clock (50 MHz nominal)
- rst  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe: key_code holds a new debounced press
- key_code  input  4  0-9 digits, 10=A(+), 11=B(-), 12=C(*), 13=D(/), 14=# (equals), 15=* (clear)
- op_valid  output  1  expression available
- op_ready  input  1  calculator core accepts expression
- operand_a  output  4*DIGITS  BCD operand A, least significant digit in [3:0]
- operand_b  output  4*DIGITS  BCD operand B
- op_code  output  2  0=add, 1=sub, 2=mul, 3=div
- entry_value  output  4*DIGITS  BCD of operand currently being typed
- entry_count  output  4  digits entered in current operand (0..DIGITS)
- entry_sel  output  1  0=typing A, 1=typing B

## Operation
- Single clock domain, one clock. Reset is asynchronous and active-high; all state is cleared immediately on rst.
- States:
  - ENTRY_A (reset state)
  - ENTRY_B
  - ISSUE
- Digit key in ENTRY_A/ENTRY_B: new = {current[4*DIGITS-5:0], digit}, and entry_count increments.
  - Leading zero: digit 0 with entry_count==0 leaves value 0 and count 0.
  - Full: entry_count==DIGITS; further digits are ignored with no wrap and no change.
- Operator key (A-D):
  - In ENTRY_A: latch op_code and go to ENTRY_B. An empty A is valid as operand 0.
  - In ENTRY_B with count 0: replaces op_code.
  - In ENTRY_B with count>0: ignored.
- # key:
  - In ENTRY_A: ignored.
  - In ENTRY_B: go to ISSUE. An empty B is operand 0.
- * key in ENTRY_A/ENTRY_B: clears operand_a, operand_b, op_code and count, then returns to ENTRY_A (default build).
- ISSUE state:
  - op_valid=1.
  - operand_a, operand_b and op_code are held stable.
  - All keys, including *, are dropped.
  - On op_valid&&op_ready: clear operands and count, return to ENTRY_A.
- Outputs by state:
  - entry_value mirrors operand_a in ENTRY_A, operand_b in ENTRY_B, and operand_b in ISSUE.
  - entry_sel=1 in ENTRY_B and ISSUE.
- key_valid with key_code out of range cannot occur (4-bit); every code is defined above.

## Timing
- Reset values:
  - op_valid=0, op_code=0.
  - operand_a, operand_b and entry_value all 0.
  - entry_count=0, entry_sel=0.
  - State ENTRY_A.
- A key sampled at posedge N is reflected in all registered outputs after posedge N (visible during cycle N+1).
- op_valid rises one cycle after the # strobe. Handshake completes on the first edge with op_valid&&op_ready; op_valid is low the next cycle.
- op_ready while op_valid=0 has no effect.
- key_valid in the same cycle as the completing handshake is dropped.
- Back-to-back key_valid on consecutive cycles must each be processed; there is no minimum spacing.
- rst asserted mid-entry or during ISSUE forces reset values asynchronously. Any pending expression is lost, with no partial handshake.

## Configuration
- KEYPAD_ENTRY_BACKSPACE_EN defined:
  - * in ENTRY_A/ENTRY_B with entry_count>0 acts as backspace: value >>4 with 0 shifted into the top digit, count decrements.
  - * with entry_count==0 in ENTRY_B returns to ENTRY_A, keeping operand_a and its count.
  - * with entry_count==0 in ENTRY_A does a full clear.
- KEYPAD_ENTRY_BACKSPACE_EN undefined: * is always a full clear, as in Operation.

## Test plan
- Keys 1,2,A,3,4,# with op_ready=0:
  - op_valid=1 one cycle after #.
  - operand_a=16'h0012, operand_b=16'h0034, op_code=0.
  - Values stay stable for 10 cycles.
  - Raise op_ready: op_valid=0 next cycle, state ENTRY_A, all operands 0.
- Keys 0,0,7 then 9,8,7,6,5 (DIGITS=4):
  - After 0,0,7: entry_value=16'h0007, entry_count=1.
  - After all keys: entry_value=16'h7987, entry_count=4; the final 5 is ignored.
- Keys 5,C,B,2,# → op_code=1 (operator replaced), operand_a=16'h0005, operand_b=16'h0002.
- During ISSUE, press 9 and *: operands unchanged and op_valid held. # in ENTRY_A produces no state change.
- Keys 3,A,4 then rst pulse for 1 cycle mid-entry → all outputs at reset values immediately, entry_sel=0.
- With KEYPAD_ENTRY_BACKSPACE_EN, keys 1,2,3,*:
  - Result: entry_value=16'h0012, entry_count=2.
  - Then A,*: entry_sel=0 and operand_a=16'h0012 retained.
